// File: rtl/speed_ramp_ctrl.sv
// Speed switch front-end for the PWM driver: sync + debounce of active-low switches,
// target decode, and one-level-per-step soft ramp with emergency stop.
module speed_ramp_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] switch_raw,
    input  logic       estop,
    output logic [6:0] speed_switch,
    output logic [2:0] level,
    output logic       busy,
    output logic       level_step
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t        state;
    logic [6:0]    sync1, sync2, candidate, stable;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] step_cnt;
    logic [2:0]    target, nxt_level;

    function automatic logic [6:0] encode(input logic [2:0] l);
        encode = (l == 3'd0) ? 7'h7F : ~(7'd1 << (l - 3'd1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 7'h7F;
            sync2     <= 7'h7F;
            candidate <= 7'h7F;
            stable    <= 7'h7F;
            deb_cnt   <= '0;
        end else begin
            sync1 <= switch_raw;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                deb_cnt   <= '0;
            end else begin
                if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
                else                    stable  <= candidate;
            end
        end
    end

    // Highest pressed switch wins.
    always_comb begin
        target = 3'd0;
        for (int i = 0; i < 7; i++)
            if (!stable[i]) target = 3'(i + 1);
    end

    // Direction comes from the state; the FSM guarantees no wrap past 0 or 7.
    assign nxt_level = (state == RAMP_UP) ? level + 3'd1 : level - 3'd1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            step_cnt     <= '0;
            level        <= 3'd0;
            speed_switch <= 7'h7F;
            level_step   <= 1'b0;
        end else begin
            level_step <= 1'b0;
            if (estop) begin
                state        <= IDLE;
                step_cnt     <= '0;
                level        <= 3'd0;
                speed_switch <= 7'h7F;
                level_step   <= (level != 3'd0);
            end else begin
                case (state)
                    IDLE: begin
                        step_cnt <= '0;
                        if (target > level)      state <= RAMP_UP;
                        else if (target < level) state <= RAMP_DOWN;
                    end
                    RAMP_UP, RAMP_DOWN: begin
                        if (target == level) begin
                            state <= IDLE;
                        end else if ((state == RAMP_UP) != (target > level)) begin
                            state    <= (target > level) ? RAMP_UP : RAMP_DOWN;
                            step_cnt <= '0;
                        end else if (step_cnt == STEP_MAX) begin
                            step_cnt     <= '0;
                            level        <= nxt_level;
                            speed_switch <= encode(nxt_level);
                            level_step   <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Directed bench for speed_ramp_ctrl with short debounce/step periods.
module tb_speed_ramp_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] switch_raw;
    logic       estop;
    logic [6:0] speed_switch;
    logic [2:0] level;
    logic       busy;
    logic       level_step;

    int n_chk = 0;
    int n_err = 0;
    int pulses = 0;
    int gap;

    speed_ramp_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .switch_raw(switch_raw), .estop(estop),
        .speed_switch(speed_switch), .level(level), .busy(busy), .level_step(level_step)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (level_step) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] code_of(input int l);
        logic [6:0] one;
        one = 7'd1;
        code_of = (l == 0) ? 7'h7F : ~(one << (l - 1));
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    // Waits for the next level_step pulse; returns cycles taken, or -1 on timeout.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
        end while (!level_step && n < 200);
        if (!level_step) begin
            chk("step_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic step_expect(input string tag, input int lvl, input int gap_exp);
        wait_step(gap);
        chk({tag, "_level"}, 32'(level), 32'(lvl));
        chk({tag, "_code"}, 32'(speed_switch), 32'(code_of(lvl)));
        if (gap_exp >= 0) chk({tag, "_gap"}, gap, gap_exp);
    endtask

    initial begin
        int p0, n;
        rst = 1'b1; switch_raw = 7'h7F; estop = 1'b0;
        cyc(3);
        chk("rst_code", 32'(speed_switch), 32'h7F);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_step", 32'(level_step), 0);
        rst = 1'b0;
        cyc(5);

        // Short glitch must not be accepted.
        p0 = pulses;
        switch_raw = 7'b0111111;
        cyc(2);
        switch_raw = 7'h7F;
        cyc(20);
        chk("glitch_stable", 32'(dut.stable), 32'h7F);
        chk("glitch_level", 32'(level), 0);
        chk("glitch_pulses", pulses - p0, 0);
        chk("glitch_busy", 32'(busy), 0);

        // Ramp to level 3.
        switch_raw = 7'b1111011;
        n = 0;
        while (!busy && n < 50) begin cyc(1); n++; end
        chk("r3_busy", 32'(busy), 1);
        step_expect("r3_1", 1, 8);
        step_expect("r3_2", 2, 8);
        step_expect("r3_3", 3, 8);
        cyc(1);
        chk("r3_idle", 32'(busy), 0);

        // Target 7 from level 3.
        switch_raw = 7'b0111110;
        step_expect("r7_4", 4, -1);
        step_expect("r7_5", 5, 8);
        step_expect("r7_6", 6, 8);
        step_expect("r7_7", 7, 8);
        cyc(1);
        chk("r7_idle", 32'(busy), 0);
        chk("r7_code", 32'(speed_switch), 32'h3F);

        // Soft stop 7 -> 0.
        switch_raw = 7'h7F;
        step_expect("dn_6", 6, -1);
        for (int l = 5; l >= 0; l--) step_expect("dn", l, 8);
        cyc(1);
        chk("dn_idle", 32'(busy), 0);
        chk("dn_code", 32'(speed_switch), 32'h7F);

        // Reverse direction mid-ramp at level 3.
        switch_raw = 7'b0111110;
        step_expect("rv_1", 1, -1);
        step_expect("rv_2", 2, 8);
        step_expect("rv_3", 3, 8);
        switch_raw = 7'h7F;
        step_expect("rv_down2", 2, 16);
        step_expect("rv_down1", 1, 8);
        step_expect("rv_down0", 0, 8);
        cyc(1);
        chk("rv_idle", 32'(busy), 0);

        // Emergency stop at level 5.
        switch_raw = 7'b0111110;
        step_expect("es_1", 1, -1);
        for (int l = 2; l <= 5; l++) step_expect("es_up", l, 8);
        estop = 1'b1;
        cyc(1);
        chk("es_level", 32'(level), 0);
        chk("es_code", 32'(speed_switch), 32'h7F);
        chk("es_pulse", 32'(level_step), 1);
        chk("es_busy", 32'(busy), 0);
        estop = 1'b0;
        cyc(1);
        chk("es_pulse_end", 32'(level_step), 0);
        chk("es_rebusy", 32'(busy), 1);
        step_expect("es_re1", 1, 8);
        step_expect("es_re2", 2, 8);
        step_expect("es_re3", 3, 8);
        step_expect("es_re4", 4, 8);

        // Asynchronous reset mid-ramp at level 4.
        cyc(2);
        #3 rst = 1'b1;
        #1;
        chk("ar_code", 32'(speed_switch), 32'h7F);
        chk("ar_level", 32'(level), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_step", 32'(level_step), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
